// File: rtl/bus_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_timer_pkg
//  Purpose  : Shared definitions for the bus_timer responder: data and
//             register-index widths, register index constants, CTRL/INTR bit
//             positions and the active-low bus polarity constants.
//  Ports    : none (package)
//  Config   : BUS_TIMER_PRESCALER_EN enables the PRESCALE register (index 4)
//  Revision : 1.0  initial release
// ============================================================================
package bus_timer_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    // Register indices
    localparam logic [ADDR_W-1:0] TIMER_ADDR_CTRL     = 3'd0;
    localparam logic [ADDR_W-1:0] TIMER_ADDR_INTR     = 3'd1;
    localparam logic [ADDR_W-1:0] TIMER_ADDR_EXPR     = 3'd2;
    localparam logic [ADDR_W-1:0] TIMER_ADDR_COUNTER  = 3'd3;
    localparam logic [ADDR_W-1:0] TIMER_ADDR_PRESCALE = 3'd4;

    // Bit positions
    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_PERIODIC_BIT = 1;
    localparam int INTR_EXPIRE_BIT   = 0;

    // Bus polarity (strobes are active low)
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

endpackage : bus_timer_pkg
`default_nettype wire

// File: rtl/bus_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : bus_timer_prescaler
//  Purpose  : Divides the timer tick rate. While enabled, an internal counter
//             runs 0..prescale and a tick is issued when it equals prescale,
//             so prescale = 0 yields one tick per cycle.
//  Ports    : clk      - system clock
//             reset    - synchronous active-high reset
//             enable   - count enable (timer START)
//             clear    - return the internal counter to 0 (CTRL write)
//             prescale - terminal count
//             tick     - one-cycle tick qualifier for the timer counter
//  Config   : only compiled when BUS_TIMER_PRESCALER_EN is defined, since it
//             is only instantiated in that build
//  Revision : 1.0  initial release
// ============================================================================
`ifdef BUS_TIMER_PRESCALER_EN
module bus_timer_prescaler
    import bus_timer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [DATA_W-1:0] prescale,
    output logic              tick
);

    logic [DATA_W-1:0] r_count;
    logic              w_at_limit;

    assign w_at_limit = (r_count == prescale);
    assign tick       = enable && w_at_limit;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (w_at_limit) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule : bus_timer_prescaler
`endif
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_timer
//  Purpose  : Memory-mapped interval timer on the active-low request/strobe
//             bus. Counts ticks up to EXPR, raises a level interrupt on
//             expiry, optionally reloads (PERIODIC). Every access completes
//             with a one-cycle rdy_ pulse in the cycle after it is sampled.
//  Ports    : clk     - system clock (rising edge)
//             reset   - synchronous active-high reset
//             cs_     - chip select, active low
//             as_     - address strobe, active low
//             rw      - 1 = read, 0 = write
//             addr    - register index
//             wr_data - write data
//             rd_data - read data, zero outside a read response
//             rdy_    - access-complete strobe, active low
//             irq     - timer interrupt (INTR bit0), active high
//  Config   : BUS_TIMER_PRESCALER_EN adds PRESCALE (index 4) and a prescaler
//  Revision : 1.0  initial release
// ============================================================================
module bus_timer
    import bus_timer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    output logic              irq
);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic              r_start;
    logic              r_periodic;
    logic              r_intr;
    logic [DATA_W-1:0] r_expr;
    logic [DATA_W-1:0] r_counter;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rdy_;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_access;
    logic w_wr;
    logic w_rd;
    logic w_wr_ctrl;
    logic w_wr_intr;
    logic w_wr_expr;
    logic w_wr_counter;

    assign w_access     = (cs_ == ENABLE_) && (as_ == ENABLE_);
    assign w_wr         = w_access && (rw == WRITE);
    assign w_rd         = w_access && (rw == READ);
    assign w_wr_ctrl    = w_wr && (addr == TIMER_ADDR_CTRL);
    assign w_wr_intr    = w_wr && (addr == TIMER_ADDR_INTR);
    assign w_wr_expr    = w_wr && (addr == TIMER_ADDR_EXPR);
    assign w_wr_counter = w_wr && (addr == TIMER_ADDR_COUNTER);

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    logic w_tick;
    logic w_match;
    logic w_expire;

`ifdef BUS_TIMER_PRESCALER_EN
    logic [DATA_W-1:0] r_prescale;
    logic              w_wr_prescale;

    assign w_wr_prescale = w_wr && (addr == TIMER_ADDR_PRESCALE);

    bus_timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (r_start),
        .clear    (w_wr_ctrl),
        .prescale (r_prescale),
        .tick     (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescale <= '0;
        end else if (w_wr_prescale) begin
            r_prescale <= wr_data;
        end
    end
`else
    assign w_tick = r_start;
`endif

    assign w_match  = (r_counter == r_expr);
    assign w_expire = w_tick && w_match;

    // ------------------------------------------------------------------
    // Read mux: reflects register state before the sampling edge
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rd_mux;

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            TIMER_ADDR_CTRL: begin
                w_rd_mux[CTRL_START_BIT]    = r_start;
                w_rd_mux[CTRL_PERIODIC_BIT] = r_periodic;
            end
            TIMER_ADDR_INTR:     w_rd_mux[INTR_EXPIRE_BIT] = r_intr;
            TIMER_ADDR_EXPR:     w_rd_mux = r_expr;
            TIMER_ADDR_COUNTER:  w_rd_mux = r_counter;
`ifdef BUS_TIMER_PRESCALER_EN
            TIMER_ADDR_PRESCALE: w_rd_mux = r_prescale;
`endif
            default:             w_rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register and response update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start    <= 1'b0;
            r_periodic <= 1'b0;
            r_intr     <= 1'b0;
            r_expr     <= '0;
            r_counter  <= '0;
            r_rd_data  <= '0;
            r_rdy_     <= DISABLE_;
        end else begin
            // One-cycle response to every sampled access
            r_rdy_    <= w_access ? ENABLE_ : DISABLE_;
            r_rd_data <= w_rd ? w_rd_mux : '0;

            // A CTRL write overrides the one-shot auto-stop
            if (w_wr_ctrl) begin
                r_start    <= wr_data[CTRL_START_BIT];
                r_periodic <= wr_data[CTRL_PERIODIC_BIT];
            end else if (w_expire && !r_periodic) begin
                r_start <= 1'b0;
            end

            // Expiry wins over a clearing write so no interrupt is lost
            if (w_expire) begin
                r_intr <= 1'b1;
            end else if (w_wr_intr && !wr_data[INTR_EXPIRE_BIT]) begin
                r_intr <= 1'b0;
            end

            if (w_wr_expr) begin
                r_expr <= wr_data;
            end

            // A COUNTER write overrides both increment and expiry reload
            if (w_wr_counter) begin
                r_counter <= wr_data;
            end else if (w_tick) begin
                r_counter <= w_match ? '0 : r_counter + 1'b1;
            end
        end
    end

    assign rd_data = r_rd_data;
    assign rdy_    = r_rdy_;
    assign irq     = r_intr;

endmodule : bus_timer
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_timer
//  Purpose  : Self-checking bench for bus_timer. Every access pushes its
//             expected response (data and due cycle) to a scoreboard; a
//             negedge monitor pops and compares on each rdy_ pulse.
//  Config   : expectations follow BUS_TIMER_PRESCALER_EN when defined
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_timer;

    logic        clk;
    logic        reset;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [2:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;
    logic        irq;

    bus_timer dut (
        .clk     (clk),
        .reset   (reset),
        .cs_     (cs_),
        .as_     (as_),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rdy_    (rdy_),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge count; read at negedges only
    logic [31:0] pcyc;
    initial pcyc = '0;
    always @(posedge clk) pcyc = pcyc + 1;

    int total;
    int bad;
    initial begin
        total = 0;
        bad   = 0;
    end

    typedef struct {
        logic [31:0] data;
        logic [31:0] due;
        string       tag;
    } sb_t;

    sb_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, pcyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        sb_t e;
        if (rdy_ === 1'b0) begin
            if (sb.size() == 0) begin
                check_val("spurious_rdy", {31'b0, rdy_}, 32'd1);
            end else begin
                e = sb.pop_front();
                check_val({e.tag, "_lat"}, pcyc, e.due);
                check_val(e.tag, rd_data, e.data);
            end
        end else if (sb.size() > 0 && sb[0].due <= pcyc) begin
            e = sb.pop_front();
            check_val({e.tag, "_rdy_missing"}, {31'b0, rdy_}, 32'd0);
        end
    end

    task automatic bus_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cs_ = 1'b1;
            as_ = 1'b1;
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input string tag);
        sb_t e;
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
        e.data = '0; e.due = pcyc + 1; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        sb_t e;
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a; wr_data = '0;
        e.data = exp; e.due = pcyc + 1; e.tag = tag;
        sb.push_back(e);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

`ifdef BUS_TIMER_PRESCALER_EN
    localparam int C_PRE_WAIT = 6;
    localparam logic [31:0] C_PRE_RD = 32'd2;
`else
    localparam int C_PRE_WAIT = 2;
    localparam logic [31:0] C_PRE_RD = 32'd0;
`endif

    initial begin
        reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1. Reset state and reads of all indices
        check_val("rst_rdy", {31'b0, rdy_}, 32'd1);
        check_val("rst_rd_data", rd_data, 32'd0);
        check_val("rst_irq", {31'b0, irq}, 32'd0);
        for (int i = 0; i < 8; i++) bus_rd(3'(i), 32'd0, $sformatf("rst_rd%0d", i));
        bus_idle(1);

        // 2. One-shot
        bus_wr(3'd2, 32'd3, "wr_expr3");
        bus_wr(3'd0, 32'h1, "wr_ctrl1");
        bus_idle(4);
        check_val("oneshot_irq_early", {31'b0, irq}, 32'd0);
        bus_idle(1);
        check_val("oneshot_irq", {31'b0, irq}, 32'd1);
        bus_rd(3'd0, 32'd0, "oneshot_ctrl");
        bus_rd(3'd3, 32'd0, "oneshot_counter");
        bus_rd(3'd1, 32'd1, "oneshot_intr");
        bus_wr(3'd1, 32'd0, "oneshot_clr");
        bus_idle(1);
        check_val("oneshot_irq_clr", {31'b0, irq}, 32'd0);

        // 3. Periodic: expiries every second edge after CTRL write
        bus_wr(3'd2, 32'd1, "wr_expr1");
        bus_wr(3'd0, 32'h3, "wr_ctrl3");
        bus_idle(3);
        check_val("per_irq1", {31'b0, irq}, 32'd1);
        bus_wr(3'd1, 32'd0, "per_clr_collide");
        bus_idle(1);
        check_val("per_collide_irq", {31'b0, irq}, 32'd1);
        bus_idle(1);
        bus_wr(3'd1, 32'd0, "per_clr");
        bus_idle(1);
        check_val("per_irq_clr", {31'b0, irq}, 32'd0);
        bus_idle(1);
        check_val("per_irq2", {31'b0, irq}, 32'd1);
        bus_rd(3'd0, 32'h3, "per_ctrl");

        // 4. Wrap and COUNTER write collision with expiry
        bus_wr(3'd0, 32'h0, "wrap_stop");
        bus_wr(3'd1, 32'd0, "wrap_clr");
        bus_wr(3'd2, 32'd5, "wrap_expr");
        bus_wr(3'd3, 32'hFFFF_FFFF, "wrap_cnt");
        bus_wr(3'd0, 32'h1, "wrap_start");
        bus_rd(3'd3, 32'hFFFF_FFFF, "wrap_cnt_max");
        bus_rd(3'd3, 32'd0, "wrap_cnt_zero");
        bus_idle(4);
        bus_wr(3'd3, 32'h10, "wrap_cnt_collide");
        bus_idle(1);
        check_val("wrap_irq", {31'b0, irq}, 32'd1);
        bus_rd(3'd3, 32'h10, "wrap_cnt_kept");
        bus_rd(3'd0, 32'h0, "wrap_ctrl");

        // 5. Pipelined reads, then reset while a response is pending
        bus_wr(3'd1, 32'd0, "pipe_clr");
        bus_wr(3'd2, 32'h1234_5678, "pipe_expr");
        bus_wr(3'd0, 32'h2, "pipe_ctrl");
        bus_rd(3'd0, 32'h2, "pipe_rd0");
        bus_rd(3'd1, 32'h0, "pipe_rd1");
        bus_rd(3'd2, 32'h1234_5678, "pipe_rd2");
        bus_rd(3'd3, 32'h10, "pipe_rd3");
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 3'd2; reset = 1'b1;
        @(negedge clk);
        check_val("midrst_rdy", {31'b0, rdy_}, 32'd1);
        check_val("midrst_rd_data", rd_data, 32'd0);
        cs_ = 1'b1; as_ = 1'b1; reset = 1'b0;
        bus_rd(3'd2, 32'd0, "midrst_expr");
        bus_rd(3'd3, 32'd0, "midrst_counter");

        // 6. Prescaler (or plain tick rate in default build)
        bus_wr(3'd4, 32'd2, "pre_wr");
        bus_wr(3'd2, 32'd1, "pre_expr");
        bus_wr(3'd0, 32'h1, "pre_start");
        bus_idle(C_PRE_WAIT);
        check_val("pre_irq_early", {31'b0, irq}, 32'd0);
        bus_idle(1);
        check_val("pre_irq", {31'b0, irq}, 32'd1);
        bus_rd(3'd4, C_PRE_RD, "pre_rd4");

        bus_idle(3);
        check_val("sb_drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_timer
`default_nettype wire
